maple_tx: RTL



---
 rtl/maple_pkg.sv | 30 +++
 rtl/maple_phase_timer.sv | 28 ++
 rtl/maple_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/maple_pkg.sv
// Shared definitions for the Maple bus transmitter: state encoding,
// slot counts and the fixed start/end line patterns.
package maple_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_END   = 2'd3
  } state_t;

  localparam int START_SLOTS    = 10;
  localparam int END_SLOTS      = 6;
  localparam int SLOTS_PER_BYTE = 16;

  // Start pattern {A,B}: (0,1), then (0,0),(0,1) four times, then (1,1).
  // Odd slots carry the B falling edges while A is held low.
  function automatic logic [1:0] start_ab(input logic [3:0] idx);
    if (idx == 4'd0)                         return 2'b01;
    else if (idx == 4'(START_SLOTS - 1))     return 2'b11;
    else                                     return idx[0] ? 2'b00 : 2'b01;
  endfunction

  // End pattern {A,B}: (1,0),(0,0),(1,0),(0,0),(1,0),(1,1).
  function automatic logic [1:0] end_ab(input logic [3:0] idx);
    if (idx == 4'(END_SLOTS - 1))            return 2'b11;
    else                                     return idx[0] ? 2'b00 : 2'b10;
  endfunction

endpackage

// File: rtl/maple_phase_timer.sv
// Slot prescaler: counts PHASE_CLKS cycles per line slot. Flags the final
// cycle of a slot and the one before it, so registered outputs that must be
// valid on the final cycle can be decided one cycle early.
module maple_phase_timer #(
  parameter int PHASE_CLKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic slot_last,
  output logic slot_prelast
);

  localparam int CW = (PHASE_CLKS > 1) ? $clog2(PHASE_CLKS) : 1;

  logic [CW-1:0] cnt;

  assign slot_last    = (cnt == CW'(PHASE_CLKS - 1));
  assign slot_prelast = (cnt == CW'(PHASE_CLKS - 2));

  // Free-running modulo-PHASE_CLKS counter, realigned when a frame starts.
  always_ff @(posedge clk) begin
    if (rst || clear)   cnt <= '0;
    else if (slot_last) cnt <= '0;
    else                cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/maple_tx.sv
// Maple bus frame transmitter. Pulls bytes from the TX FIFO and drives
// start pattern, MSB-first data bits and end pattern onto SDCKA/SDCKB.
// All outputs are registered from next-state values, so line changes land
// exactly on slot boundaries.
import maple_pkg::*;

module maple_tx #(
  parameter int PHASE_CLKS = 10,
  parameter int LEN_BITS   = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_BITS-1:0] len,
  input  logic [7:0]          fifo_data,
  input  logic                fifo_avail,
  output logic                fifo_strobe,
  output logic                sdcka_out,
  output logic                sdckb_out,
  output logic                drive_oe,
  output logic                busy,
  output logic                done,
  output logic                underrun
);

  state_t              state, state_n;
  logic [3:0]          slot, slot_n;
  logic [7:0]          sh, sh_n;
  logic [LEN_BITS-1:0] rem, rem_n;
  logic                und_n, done_n, strobe_n;
  logic [1:0]          ab_n;
  logic [2:0]          bit_k;
  logic                slot_last, slot_prelast;
  logic                accept, fetch_slot;

  assign accept     = (state == ST_IDLE) && start && (len != '0);
  assign fetch_slot = ((state == ST_START) && (slot == 4'(START_SLOTS - 1))) ||
                      ((state == ST_DATA)  && (slot == 4'(SLOTS_PER_BYTE - 1)));
  // Pop decided one cycle ahead so the registered strobe sits on the
  // final cycle of the fetch slot, where fifo_data is captured.
  assign strobe_n   = fetch_slot && slot_prelast && (rem != '0) && fifo_avail;

  maple_phase_timer #(.PHASE_CLKS(PHASE_CLKS)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .clear        (accept),
    .slot_last    (slot_last),
    .slot_prelast (slot_prelast)
  );

  // Next-state: slot sequencing, byte fetch and underrun detection.
  always_comb begin
    state_n = state;
    slot_n  = slot;
    sh_n    = sh;
    rem_n   = rem;
    und_n   = underrun;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n = ST_START;
          slot_n  = '0;
          rem_n   = len;
          und_n   = 1'b0;
        end
      end
      ST_START, ST_DATA: begin
        if (slot_last) begin
          if (fetch_slot) begin
            slot_n = '0;
            if (fifo_strobe) begin
              sh_n    = fifo_data;
              rem_n   = rem - LEN_BITS'(1);
              state_n = ST_DATA;
            end else begin
              // Bytes still owed but none fetched: abort the frame.
              und_n   = (rem != '0);
              state_n = ST_END;
            end
          end else begin
            slot_n = slot + 4'd1;
          end
        end
      end
      ST_END: begin
        if (slot_last) begin
          if (slot == 4'(END_SLOTS - 1)) begin
            state_n = ST_IDLE;
            slot_n  = '0;
            done_n  = 1'b1;
          end else begin
            slot_n = slot + 4'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Line values for the upcoming cycle. Even bits (b7,b5,b3,b1) strobe on
  // A with data on B; odd bits strobe on B with data on A.
  always_comb begin
    ab_n  = 2'b11;
    bit_k = slot_n[3:1];
    case (state_n)
      ST_START: ab_n = start_ab(slot_n);
      ST_DATA: begin
        if (!bit_k[0]) ab_n = {~slot_n[0], sh_n[~bit_k]};
        else           ab_n = {sh_n[~bit_k], ~slot_n[0]};
      end
      ST_END:   ab_n = end_ab(slot_n);
      default:  ab_n = 2'b11;
    endcase
  end

  // State and registered outputs; reset returns to idle with lines released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      slot        <= '0;
      sh          <= '0;
      rem         <= '0;
      underrun    <= 1'b0;
      done        <= 1'b0;
      fifo_strobe <= 1'b0;
      sdcka_out   <= 1'b1;
      sdckb_out   <= 1'b1;
      drive_oe    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      slot        <= slot_n;
      sh          <= sh_n;
      rem         <= rem_n;
      underrun    <= und_n;
      done        <= done_n;
      fifo_strobe <= strobe_n;
      sdcka_out   <= ab_n[1];
      sdckb_out   <= ab_n[0];
      drive_oe    <= (state_n != ST_IDLE);
      busy        <= (state_n != ST_IDLE);
    end
  end

endmodule
